mbist_march_ctrl: RTL and testbench

- Single-port MBIST controller that runs the March C- algorithm over a bit-wide test RAM.
- Sequences addresses and read/write operations, and drives the existing mbist_pattern_gen (compiled in its default solid-data mode) for write data and expected read data.
- Compares read data against expected data, and reports done, fail and first-fail location to the test access logic.
- Sits between the test access logic and the RAM's BIST-mux port.

---
 rtl/mbist_pkg.sv | 49 ++++
 rtl/mbist_march_ctrl_if.sv | 29 ++
 rtl/mbist_pattern_gen.sv | 14 +
 rtl/mbist_march_ctrl.sv | 145 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
// Each element is described by one bit in several per-element vectors.
package mbist_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int unsigned NUM_ELEM = 6;

   // bit e describes March element e
   localparam logic [NUM_ELEM-1:0] ELEM_DOWN   = 6'b011000;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_RD = 6'b111110;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_WR = 6'b011111;
   localparam logic [NUM_ELEM-1:0] ELEM_RD_VAL = 6'b010100;
   localparam logic [NUM_ELEM-1:0] ELEM_WR_VAL = 6'b001010;

   typedef struct packed {
      logic       we;
      logic       re;
      logic [1:0] pat_en;
   } ops_t;

   // Strobes and pattern select to present while in state s of element e
   function automatic ops_t op_outs(state_t s, logic [2:0] e);
      ops_t o;
      o = '0;
      unique case (s)
         S_WR: begin
            o.we     = 1'b1;
            o.pat_en = {1'b1, ELEM_WR_VAL[e]};
         end
         S_RD: begin
            o.re     = 1'b1;
            o.pat_en = {1'b1, ELEM_RD_VAL[e]};
         end
         S_CMP: begin
            o.pat_en = {1'b1, ELEM_RD_VAL[e]};
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Test-access and RAM-side signal bundle of the MBIST controller.
// master: the controller; slave: test access logic plus RAM.
interface mbist_march_ctrl_if #(
   parameter int ADDR = 8
);
   logic            start;
   logic            busy;
   logic            done;
   logic            fail;
   logic [ADDR-1:0] fail_addr;
   logic [2:0]      fail_elem;
   logic [ADDR-1:0] mem_addr;
   logic            mem_we;
   logic            mem_re;
   logic            mem_wdata;
   logic            mem_rdata;

   modport master (
      input  start, mem_rdata,
      output busy, done, fail, fail_addr, fail_elem,
      output mem_addr, mem_we, mem_re, mem_wdata
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, fail, fail_addr, fail_elem,
      input  mem_addr, mem_we, mem_re, mem_wdata
   );
endinterface

// File: rtl/mbist_pattern_gen.sv
// Data background generator: pat_en = {enable, data bit}.
// MODE 0 is solid data; MODE 1 inverts by address parity.
module mbist_pattern_gen #(
   parameter int ADDR = 8,
   parameter int MODE = 0
) (
   input  logic [ADDR-1:0] addr_i,
   input  logic [1:0]      pat_en_i,
   output logic            pat_o
);
   localparam logic CHK = (MODE == 1);

   assign pat_o = pat_en_i[1] & (pat_en_i[0] ^ (CHK & (^addr_i)));
endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for a single-port bit-wide RAM.
// Runs six elements, compares reads, records the first failure.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int ADDR = 8
) (
   input  logic               clk,
   input  logic               rst,
   mbist_march_ctrl_if.master bus
);
   state_t          state_q;
   logic [ADDR-1:0] addr_q;
   logic [2:0]      elem_q;
   logic            exp_q;
   logic            busy_q;
   logic            done_q;
   logic            fail_q;
   logic [ADDR-1:0] fail_addr_q;
   logic [2:0]      fail_elem_q;
   ops_t            ops_q;
   logic            pat;

   logic [ADDR-1:0] adv_addr_d;
   logic [2:0]      adv_elem_d;
   logic            adv_done_d;
   state_t          adv_state_d;
   logic            last_addr;
   logic [2:0]      nxt_elem;

   mbist_pattern_gen #(
      .ADDR (ADDR)
   ) u_pat (
      .addr_i   (addr_q),
      .pat_en_i (ops_q.pat_en),
      .pat_o    (pat)
   );

   // Where the march goes after the current address finishes its ops
   always_comb begin
      adv_addr_d  = addr_q;
      adv_elem_d  = elem_q;
      adv_done_d  = 1'b0;
      adv_state_d = S_DONE;
      nxt_elem    = elem_q + 3'd1;
      last_addr   = ELEM_DOWN[elem_q] ? (addr_q == '0)
                                      : (addr_q == '1);
      if (!last_addr) begin
         adv_addr_d = ELEM_DOWN[elem_q] ? addr_q - 1'b1
                                        : addr_q + 1'b1;
      end else if (elem_q == 3'(NUM_ELEM - 1)) begin
         adv_done_d = 1'b1;
      end else begin
         adv_elem_d = nxt_elem;
         adv_addr_d = ELEM_DOWN[nxt_elem] ? '1 : '0;
      end
      if (!adv_done_d) begin
         adv_state_d = ELEM_HAS_RD[adv_elem_d] ? S_RD : S_WR;
      end
   end

   // Main sequencer; strobes are registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         elem_q      <= '0;
         exp_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         ops_q       <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_q     <= S_WR;
                  addr_q      <= '0;
                  elem_q      <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_elem_q <= '0;
                  ops_q       <= op_outs(S_WR, 3'd0);
               end
            end
            S_WR: begin
               state_q <= adv_state_d;
               addr_q  <= adv_addr_d;
               elem_q  <= adv_elem_d;
               ops_q   <= op_outs(adv_state_d, adv_elem_d);
               if (adv_done_d) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            S_RD: begin
               exp_q   <= pat;
               state_q <= S_CMP;
               ops_q   <= op_outs(S_CMP, elem_q);
            end
            S_CMP: begin
               if (bus.mem_rdata != exp_q) begin
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  fail_q      <= 1'b1;
                  fail_addr_q <= addr_q;
                  fail_elem_q <= elem_q;
                  ops_q       <= '0;
               end else if (ELEM_HAS_WR[elem_q]) begin
                  state_q <= S_WR;
                  ops_q   <= op_outs(S_WR, elem_q);
               end else begin
                  state_q <= adv_state_d;
                  addr_q  <= adv_addr_d;
                  elem_q  <= adv_elem_d;
                  ops_q   <= op_outs(adv_state_d, adv_elem_d);
                  if (adv_done_d) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               ops_q   <= '0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fail      = fail_q;
   assign bus.fail_addr = fail_addr_q;
   assign bus.fail_elem = fail_elem_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_we    = ops_q.we;
   assign bus.mem_re    = ops_q.re;
   assign bus.mem_wdata = ops_q.we & pat;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: 16-cell RAM model with injectable faults.
// Cycle 0 is the cycle in which start is high.
module tb_mbist_march_ctrl;
   localparam int AW = 4;
   localparam int N  = 16;

   typedef struct {
      string name;
      int    s1;
      int    s0;
      bit    coup;
      int    done_cyc;
      int    fail;
      int    faddr;
      int    felem;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mbist_march_ctrl_if #(.ADDR(AW)) bus ();

   mbist_march_ctrl #(.ADDR(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [N-1:0] mem;
   logic         rd_q;
   int           s1 = -1;
   int           s0 = -1;
   bit           coup = 1'b0;
   bit           ram_clr = 1'b0;

   assign bus.mem_rdata = rd_q;

   // RAM model: 1-cycle read latency, stuck-at and coupling faults
   always @(posedge clk) begin
      if (ram_clr) begin
         mem <= '0;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         if (coup && bus.mem_addr == 4'd9 && bus.mem_wdata)
            mem[8] <= 1'b1;
      end
      if (bus.mem_re) begin
         if (int'(bus.mem_addr) == s1)      rd_q <= 1'b1;
         else if (int'(bus.mem_addr) == s0) rd_q <= 1'b0;
         else                               rd_q <= mem[bus.mem_addr];
      end
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({bus.busy, bus.done, bus.fail, bus.fail_addr,
                   bus.fail_elem, bus.mem_addr, bus.mem_we,
                   bus.mem_re, bus.mem_wdata});
   endfunction

   // Called at cycle 0 (just after an edge); returns in the done cycle
   task automatic run(input int pulse_at, output int dcyc,
                      output int busy_bad, output int strobe_bad);
      dcyc = -1;
      busy_bad = 0;
      strobe_bad = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (bus.mem_we && bus.mem_re) strobe_bad++;
         if (bus.done) begin
            dcyc = c;
            break;
         end
         if (!bus.busy) busy_bad++;
         @(posedge clk); #1;
         bus.start = (c + 1 == pulse_at);
      end
      bus.start = 1'b0;
   endtask

   task automatic clear_ram();
      ram_clr = 1'b1;
      @(posedge clk); #1;
      ram_clr = 1'b0;
   endtask

   vec_t vt[4];
   int   dc, bb, sb, cnt;

   initial begin
      vt[0] = '{"clean", -1, -1, 1'b0, 241, 0, 0, 0};
      vt[1] = '{"sa1_a3", 3, -1, 1'b0, 28, 1, 3, 1};
      vt[2] = '{"sa0_a5", -1, 5, 1'b0, 82, 1, 5, 2};
      vt[3] = '{"cf_9to8", -1, -1, 1'b1, 136, 1, 8, 3};

      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", all_outs(), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_no_start", all_outs(), 0);

      foreach (vt[i]) begin
         s1 = vt[i].s1;
         s0 = vt[i].s0;
         coup = vt[i].coup;
         clear_ram();
         run(-1, dc, bb, sb);
         chk({vt[i].name, "_done_cyc"}, dc, vt[i].done_cyc);
         chk({vt[i].name, "_fail"}, int'(bus.fail), vt[i].fail);
         chk({vt[i].name, "_faddr"}, int'(bus.fail_addr), vt[i].faddr);
         chk({vt[i].name, "_felem"}, int'(bus.fail_elem), vt[i].felem);
         chk({vt[i].name, "_busy_at_done"}, int'(bus.busy), 0);
         chk({vt[i].name, "_busy_gaps"}, bb, 0);
         chk({vt[i].name, "_we_re_both"}, sb, 0);
         @(posedge clk); #1;
      end

      s1 = -1;
      s0 = -1;
      coup = 1'b0;
      clear_ram();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      chk("mid_run_busy_c100", int'(bus.busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_run_rst_outs", all_outs(), 0);
      rst = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.mem_we || bus.mem_re || bus.busy) cnt++;
      end
      chk("post_rst_quiet", cnt, 0);
      @(posedge clk); #1;
      run(-1, dc, bb, sb);
      chk("post_rst_done_cyc", dc, 241);
      chk("post_rst_fail", int'(bus.fail), 0);
      @(posedge clk); #1;

      s1 = 3;
      clear_ram();
      run(10, dc, bb, sb);
      chk("busy_start_ignored_cyc", dc, 28);
      chk("busy_start_fail", int'(bus.fail), 1);
      @(posedge clk); #1;
      chk("done_held", int'(bus.done), 1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("restart_done_clr", int'(bus.done), 0);
      chk("restart_fail_clr", int'(bus.fail), 0);
      chk("restart_busy", int'(bus.busy), 1);
      chk("restart_addr0", int'(bus.mem_addr), 0);
      chk("restart_wr_elem0", int'(bus.mem_we), 1);
      chk("restart_faddr_clr", int'(bus.fail_addr), 0);
      dc = -1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dc = c;
            break;
         end
      end
      chk("restart_done_cyc", dc, 28);
      chk("restart_felem", int'(bus.fail_elem), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
